line_buffer_7row: RTL and testbench
===================================

# line_buffer_7row

Raster-to-column converter placed directly upstream of the 7x7 convolution stage. Accepts one 8-bit pixel per valid cycle in raster order and emits, per pixel, the 56-bit vertical column of that pixel and the six pixels above it in the same image column, so the convolution's 7x7 window shift register fills column by column. It also flags when the emitted column completes a full 7x7 neighbourhood.

## Interface
- IMG_WIDTH, 640: pixels per line; legal range 8..4096.
- PIX_W, 8: pixel width; fixed at 8 for compatibility with the 56-bit convolution input.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; clears all counters, state and output registers. Line RAM contents are not cleared.
- i_valid  in  1  i_pixel accepted this cycle.
- i_sof  in  1  start of frame; qualified by i_valid; marks the accepted pixel as (row 0, col 0).
- i_pixel  in  8  input pixel, raster order.
- o_valid  out  1  o_data is valid; resets to 0.
- o_data  out  56  column; [7:0] is current row y, [15:8] is y-1, …, [55:48] is y-6 (top). Resets to 0.
- o_col  out  12  column index of the emitted pixel; resets to 0.
- o_win_ok  out  1  this column completes a full 7x7 window (lines_seen = 6 and col >= 6); resets to 0.

## Operation
- Counters: col (0..IMG_WIDTH-1), lines_seen (0..6, saturating).
- Accepted pixel at col = IMG_WIDTH-1: col wraps to 0 and lines_seen increments, saturating at 6. Otherwise col increments.
- Accepted pixel with i_sof: the pixel is treated as col 0 and lines_seen 0. After it, col = 1 and lines_seen = 0. i_sof overrides any position mid-line.
- i_sof without i_valid is ignored.
- State machine:
  - EMPTY: after reset, before the first accepted pixel. A pixel is accepted only with i_sof; i_valid without i_sof is dropped and not emitted.
  - EMPTY → FILL on the first accepted i_sof pixel.
  - FILL → RUN when lines_seen reaches 6.
  - Any accepted i_sof pixel → FILL.
- Six line memories L1..L6, each IMG_WIDTH x 8, organised as a cascade, all addressed by col. On each accepted pixel at col c:
  - rd_k = L_k[c] is read.
  - L1[c] is written with the pixel.
  - L_k[c] is written with rd_(k-1), for k = 2..6.
- Lane k of o_data (bits 8k+7:8k), for k = 1..6, equals rd_k when lines_seen >= k at accept time; otherwise it is forced to 0. Lane 0 is always the pixel.
- o_win_ok = (lines_seen == 6) && (c >= 6), captured at accept time.
- No backpressure. Gaps in i_valid are allowed at any point and do not disturb the counters or the pipeline contents.

## Timing
- Fixed latency of 2 cycles. A pixel accepted at cycle t produces o_valid = 1 at t+2 with its o_data, o_col and o_win_ok.
- The pipeline is free-running and valid-tagged. Output does not depend on i_valid at t+1 or t+2.
- Stage 1 (t+1): RAM read data is registered; write data and address are delayed copies. RAM writes commit at t+1.
- Stage 2 (t+2): masking and output registers.
- Read-during-write to the same address cannot occur: consecutive accepts use different addresses because IMG_WIDTH >= 8. The RAM returns old data in that case.
- Back-to-back i_valid sustains 1 pixel per cycle.
- Reset asserted mid-frame: o_valid drops asynchronously. In-flight pixels are discarded and the state returns to EMPTY.

## Structure
- Shared package isp_pkg holds PIX_W, KERNEL_SIZE = 7, and the column-word width KERNEL_SIZE*PIX_W = 56. The convolution stage uses the same constants.
- One sub-module, line_ram: simple dual-port, IMG_WIDTH x PIX_W, registered read, old-data on read-during-write, M9K-inferable. It is instantiated 6 times in a generate loop.
- Counters, FSM and masking stay in the top module.

## Test plan
All cases use IMG_WIDTH = 8.
- Reset behaviour: reset low, then release; i_valid = 1 with pixel 0x55 and no i_sof → o_valid stays 0 and all outputs stay 0.
- First line: i_sof with pixels 1..8 back-to-back → o_valid for 8 cycles starting 2 cycles after the first accept; o_data = 0x00…0001..0x00…0008; o_col = 0..7; o_win_ok = 0.
- Full window: seven lines, row r col c pixel = 16r+c → for the row-6, col-6 output, o_data = 0x06162636465666 (top row lane first) and o_win_ok = 1; for col 5 of the same row, o_win_ok = 0.
- Gapped input: same stream as the full-window case with i_valid toggling 1010… → identical o_data, o_col and o_win_ok sequence, just spread out in time.
- Mid-line i_sof: i_sof asserted at row 3, col 4 → that pixel is emitted with o_col = 0 and lanes 1..6 = 0; the next line emits lane 1 only.
- Reset mid-frame: reset pulsed during row 6 → o_valid = 0 within the pulse; after release, i_valid without i_sof is dropped.

Source files
------------

// File: rtl/isp_pkg.sv
// Constants and types shared by the ISP front-end stages (line buffer, 7x7 convolution).
package isp_pkg;

    localparam int unsigned PIX_W       = 8;
    localparam int unsigned KERNEL_SIZE = 7;
    localparam int unsigned COL_WORD_W  = KERNEL_SIZE * PIX_W;
    localparam int unsigned COL_W       = 12;
    localparam int unsigned NUM_LINES   = KERNEL_SIZE - 1;

    typedef enum logic [1:0] {
        StEmpty,
        StFill,
        StRun
    } lb_state_e;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line memory with registered read; a read colliding with a write returns
// the old contents, which maps directly onto block RAM.
module line_ram #(
    parameter int unsigned Depth = 640,
    parameter int unsigned Width = 8,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_buffer_7row.sv
// Raster-to-column converter: emits each pixel with the six pixels above it, two cycles after
// accept, and flags columns that complete a full 7x7 neighbourhood.
module line_buffer_7row
    import isp_pkg::KERNEL_SIZE, isp_pkg::NUM_LINES, isp_pkg::COL_W;
    import isp_pkg::lb_state_e, isp_pkg::StEmpty, isp_pkg::StFill, isp_pkg::StRun;
#(
    parameter int unsigned IMG_WIDTH = 640,
    parameter int unsigned PIX_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_valid,
    input  logic                          i_sof,
    input  logic [PIX_W-1:0]              i_pixel,
    output logic                          o_valid,
    output logic [KERNEL_SIZE*PIX_W-1:0]  o_data,
    output logic [COL_W-1:0]              o_col,
    output logic                          o_win_ok
);

    localparam int unsigned     DataW     = KERNEL_SIZE * PIX_W;
    localparam int unsigned     AddrW     = $clog2(IMG_WIDTH);
    localparam logic [COL_W-1:0] LastCol  = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] WinCol   = COL_W'(KERNEL_SIZE - 1);
    localparam logic [2:0]      FullLines = 3'(NUM_LINES);

    lb_state_e        state_q, state_d;
    logic [COL_W-1:0] col_q, col_d, pos_col;
    logic [2:0]       lines_q, lines_d, pos_lines;
    logic             accept, win;

    // Stage 1: delayed write address/data alongside registered RAM read data.
    logic             v1_q, win1_q;
    logic [COL_W-1:0] col1_q;
    logic [2:0]       lines1_q;
    logic [PIX_W-1:0] pix1_q;

    logic [PIX_W-1:0] ram_wd [NUM_LINES];
    logic [PIX_W-1:0] ram_rd [NUM_LINES];
    logic [DataW-1:0] data_d;

    logic             valid_q, win_ok_q;
    logic [DataW-1:0] data_q;
    logic [COL_W-1:0] out_col_q;

    always_comb begin
        accept    = i_valid && ((state_q != StEmpty) || i_sof);
        pos_col   = i_sof ? '0 : col_q;
        pos_lines = i_sof ? '0 : lines_q;
        win       = (pos_lines == FullLines) && (pos_col >= WinCol);
        col_d     = col_q;
        lines_d   = lines_q;
        state_d   = state_q;
        if (accept) begin
            if (pos_col == LastCol) begin
                col_d   = '0;
                lines_d = (pos_lines == FullLines) ? pos_lines : pos_lines + 3'd1;
            end else begin
                col_d   = pos_col + 1'b1;
                lines_d = pos_lines;
            end
            if (i_sof) begin
                state_d = StFill;
            end
            if (lines_d == FullLines) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StEmpty;
            col_q    <= '0;
            lines_q  <= '0;
            v1_q     <= 1'b0;
            win1_q   <= 1'b0;
            col1_q   <= '0;
            lines1_q <= '0;
            pix1_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            lines_q <= lines_d;
            v1_q    <= accept;
            if (accept) begin
                win1_q   <= win;
                col1_q   <= pos_col;
                lines1_q <= pos_lines;
                pix1_q   <= i_pixel;
            end
        end
    end

    // Cascade: each line shifts its old column value down into the next line one cycle later.
    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        if (k == 0) begin : g_head
            assign ram_wd[k] = pix1_q;
        end else begin : g_tail
            assign ram_wd[k] = ram_rd[k-1];
        end

        line_ram #(
            .Depth (IMG_WIDTH),
            .Width (PIX_W)
        ) u_line_ram (
            .clk_i   (clk),
            .we_i    (v1_q),
            .waddr_i (col1_q[AddrW-1:0]),
            .wdata_i (ram_wd[k]),
            .re_i    (accept),
            .raddr_i (pos_col[AddrW-1:0]),
            .rdata_o (ram_rd[k])
        );
    end

    always_comb begin
        data_d            = '0;
        data_d[PIX_W-1:0] = pix1_q;
        for (int k = 1; k <= NUM_LINES; k++) begin
            if (lines1_q >= 3'(k)) begin
                data_d[k*PIX_W +: PIX_W] = ram_rd[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            win_ok_q  <= 1'b0;
            data_q    <= '0;
            out_col_q <= '0;
        end else begin
            valid_q  <= v1_q;
            win_ok_q <= v1_q && win1_q;
            if (v1_q) begin
                data_q    <= data_d;
                out_col_q <= col1_q;
            end
        end
    end

    assign o_valid  = valid_q;
    assign o_data   = data_q;
    assign o_col    = out_col_q;
    assign o_win_ok = win_ok_q;

endmodule

// File: tb/tb_line_buffer_7row.sv
// Directed bench for line_buffer_7row at IMG_WIDTH = 8 with a column-history reference model.
module tb_line_buffer_7row;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_sof = 1'b0;
    logic [7:0]  i_pixel = '0;
    logic        o_valid;
    logic [55:0] o_data;
    logic [11:0] o_col;
    logic        o_win_ok;

    line_buffer_7row #(
        .IMG_WIDTH (W),
        .PIX_W     (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (i_valid),
        .i_sof    (i_sof),
        .i_pixel  (i_pixel),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_col    (o_col),
        .o_win_ok (o_win_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [55:0] data;
        logic [11:0] col;
        logic        win;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [55:0] log_data[$];
    logic [11:0] log_col[$];
    logic        log_win[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          chk_en = 0;

    // Reference model: per-column history of the last six pixels written there.
    bit          m_empty = 1;
    int          m_col = 0;
    int          m_ls = 0;
    logic [7:0]  hist [W][6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_accept(input bit sof, input logic [7:0] pix);
        int   c;
        int   ls;
        exp_t e;
        c      = sof ? 0 : m_col;
        ls     = sof ? 0 : m_ls;
        e.data = {48'b0, pix};
        for (int k = 1; k <= 6; k++) begin
            if (ls >= k) e.data[k*8 +: 8] = hist[c][k-1];
        end
        e.col = 12'(c);
        e.win = (ls == 6) && (c >= 6);
        e.cyc = cyc + 2;
        q.push_back(e);
        for (int k = 5; k >= 1; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = pix;
        if (c == W - 1) begin
            m_col = 0;
            m_ls  = (ls == 6) ? 6 : ls + 1;
        end else begin
            m_col = c + 1;
            m_ls  = ls;
        end
        m_empty = 0;
    endtask

    task automatic drive(input bit v, input bit sof, input logic [7:0] pix);
        @(negedge clk);
        i_valid = v;
        i_sof   = sof;
        i_pixel = pix;
        if (v && (!m_empty || sof)) model_accept(sof, pix);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 8'h00);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
        idle(1);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic clear_log();
        log_data.delete();
        log_col.delete();
        log_win.delete();
    endtask

    task automatic window_checks(input string tag);
        logic [55:0] d;
        chk({tag, "_count"}, 64'(log_data.size()), 64'd56);
        if (log_data.size() == 56) begin
            d = log_data[54];
            chk({tag, "_r6c6_data"}, 64'(d), 64'h06162636465666);
            chk({tag, "_r6c6_col"}, 64'(log_col[54]), 64'd6);
            chk({tag, "_r6c6_win"}, 64'(log_win[54]), 64'd1);
            chk({tag, "_r6c5_win"}, 64'(log_win[53]), 64'd0);
        end
    endtask

    always @(negedge clk) begin : monitor
        bit   exp_v;
        exp_t e;
        if (chk_en) begin
            exp_v = (q.size() > 0) && (q[0].cyc == cyc);
            chk("o_valid", 64'(o_valid), 64'(exp_v));
            if (o_valid) begin
                log_data.push_back(o_data);
                log_col.push_back(o_col);
                log_win.push_back(o_win_ok);
            end
            if (exp_v) begin
                e = q.pop_front();
                chk("o_data", 64'(o_data), 64'(e.data));
                chk("o_col", 64'(o_col), 64'(e.col));
                chk("o_win_ok", 64'(o_win_ok), 64'(e.win));
            end
            while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
        end
    end

    initial begin
        logic [55:0] d;

        // Reset behaviour
        #3 reset = 1'b0;
        chk_en = 1;
        repeat (3) @(negedge clk);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_col", 64'(o_col), 64'd0);
        chk("rst_win", 64'(o_win_ok), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) drive(1, 0, 8'h55);
        idle(3);
        chk("drop_valid", 64'(o_valid), 64'd0);
        chk("drop_data", 64'(o_data), 64'd0);
        chk("drop_col", 64'(o_col), 64'd0);

        // First line
        clear_log();
        for (int c = 0; c < W; c++) drive(1, c == 0, 8'(c + 1));
        drain();
        chk("line1_count", 64'(log_data.size()), 64'd8);
        if (log_data.size() == 8) begin
            chk("line1_last_data", 64'(log_data[7]), 64'h8);
            chk("line1_last_col", 64'(log_col[7]), 64'd7);
        end

        // Full window, back-to-back
        clear_log();
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < W; c++) drive(1, r == 0 && c == 0, 8'(16 * r + c));
        drain();
        window_checks("full");

        // Same stream with alternating gaps
        clear_log();
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < W; c++) begin
                drive(1, r == 0 && c == 0, 8'(16 * r + c));
                drive(0, 0, 8'hAA);
            end
        drain();
        window_checks("gap");

        // Mid-line start of frame at row 3, col 4
        clear_log();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++) drive(1, r == 0 && c == 0, 8'(16 * r + c));
        for (int c = 0; c < 4; c++) drive(1, 0, 8'(48 + c));
        drive(1, 1, 8'h34);
        for (int c = 1; c < W; c++) drive(1, 0, 8'(8'h34 + c));
        for (int c = 0; c < W; c++) drive(1, 0, 8'(8'h40 + c));
        drain();
        chk("midsof_count", 64'(log_data.size()), 64'd44);
        if (log_data.size() == 44) begin
            d = log_data[28];
            chk("midsof_col", 64'(log_col[28]), 64'd0);
            chk("midsof_data", 64'(d), 64'h34);
            d = log_data[36];
            chk("midsof_next_data", 64'(d), 64'h3440);
        end

        // Reset pulsed during row 6
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < ((r == 6) ? 4 : W); c++) drive(1, r == 0 && c == 0, 8'(16 * r + c));
        #2 reset = 1'b0;
        q.delete();
        m_empty = 1;
        m_col   = 0;
        m_ls    = 0;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        #1 chk("midrst_valid", 64'(o_valid), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) drive(1, 0, 8'h77);
        idle(4);
        chk("post_rst_valid", 64'(o_valid), 64'd0);
        chk("post_rst_queue", 64'(q.size()), 64'd0);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
